// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the architectural PC, issues one imem request per
// instruction, holds the fetched word for decode and applies exception/eret redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_in,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StBoot, StReq, StValid} state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  wait_q, wait_d;
  logic        fault_q, fault_d;
  logic [31:0] sel_pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    wait_d  = wait_q;
    fault_d = 1'b0;

    // Redirect priority: exception over eret over the sequential/branch target.
    sel_pc = npc_in;
    if (exc_req) begin
      sel_pc = EXC_VEC;
    end else if (eret) begin
      sel_pc = epc;
    end

    unique case (state_q)
      StBoot: begin
        state_d = StReq;
      end
      StReq: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          wait_d  = '0;
          state_d = StValid;
        end else if (wait_q == WaitLast) begin
          // Bus timeout: re-issue the request at the exception vector.
          fault_d = 1'b1;
          pc_d    = EXC_VEC;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StValid: begin
        if (!stall) begin
          count_d = count_q + 32'd1;
          state_d = StReq;
          if (sel_pc[1:0] != 2'b00) begin
            pc_d    = EXC_VEC;
            fault_d = 1'b1;
          end else begin
            pc_d = sel_pc;
          end
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Request derives from state so an async reset drops it immediately.
  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = (state_q == StValid);
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a transaction-level model of the
// fetch/accept/redirect rules, plus directed reset and mid-request reset checks.
module tb_fetch_sequencer;

  localparam logic [31:0] ResetPc = 32'h0000_3000;
  localparam logic [31:0] ExcVec  = 32'h0000_4180;
  localparam int          Timeout = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] npc_in;
  logic        stall;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fault;
  logic [31:0] fetch_count;

  fetch_sequencer #(
    .RESET_PC(ResetPc),
    .EXC_VEC (ExcVec),
    .TIMEOUT (Timeout)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .npc_in     (npc_in),
    .stall      (stall),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .fault      (fault),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 = boot cycle, 1 = fetch outstanding, 2 = instruction held.
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_count;
  bit          m_fault;
  int          m_req_cycles;  // request cycles already spent on the current fetch
  int          m_lat;         // cycles memory waits before acking this fetch

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick_lat(input bit rnd);
    int r;
    if (!rnd) return 0;
    r = int'($urandom_range(0, 19));
    return (r == 0) ? 40 : (r % 4);
  endfunction

  task automatic model_reset();
    m_phase      = 0;
    m_pc         = ResetPc;
    m_instr      = '0;
    m_count      = '0;
    m_fault      = 1'b0;
    m_req_cycles = 0;
    m_lat        = 0;
  endtask

  // Called at posedge+1: reset pulse, reset-state checks, release before the next edge.
  task automatic pulse_reset(input bit ack_during);
    rst_n    = 1'b0;
    imem_ack = ack_during;
    #1;
    check_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_pc", pc_out, ResetPc);
    check_eq("rst_count", fetch_count, 32'd0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr_out, 32'd0);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit rnd);
    logic [31:0] tgt;
    if (rnd) begin
      stall   = ($urandom_range(0, 2) == 0);
      exc_req = ($urandom_range(0, 5) == 0);
      eret    = ($urandom_range(0, 5) == 0);
      epc     = ResetPc + {20'd0, 10'($urandom_range(0, 1023)), 2'b00}
                + (($urandom_range(0, 5) == 0) ? 32'd1 : 32'd0);
      case ($urandom_range(0, 7))
        0:       npc_in = m_pc + 32'd2;
        1:       npc_in = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        default: npc_in = m_pc + 32'd4;
      endcase
    end else begin
      stall   = 1'b0;
      exc_req = 1'b0;
      eret    = 1'b0;
      epc     = '0;
      npc_in  = m_pc + 32'd4;
    end
    if (m_phase == 1) imem_ack = (m_req_cycles >= m_lat);
    else              imem_ack = rnd && ($urandom_range(0, 3) == 0);
    imem_rdata = $urandom;

    @(negedge clk);
    check_eq("pc_out", pc_out, m_pc);
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, m_phase == 1});
    if (m_phase == 1) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == 2});
    check_eq("instr_out", instr_out, m_instr);
    check_eq("fault", {31'd0, fault}, {31'd0, m_fault});
    check_eq("fetch_count", fetch_count, m_count);

    m_fault = 1'b0;
    case (m_phase)
      0: begin
        m_phase      = 1;
        m_req_cycles = 0;
        m_lat        = pick_lat(rnd);
      end
      1: begin
        m_req_cycles++;
        if (imem_ack) begin
          m_instr = imem_rdata;
          m_phase = 2;
        end else if (m_req_cycles == Timeout) begin
          m_fault      = 1'b1;
          m_pc         = ExcVec;
          m_req_cycles = 0;
          m_lat        = pick_lat(rnd);
        end
      end
      default: begin
        if (!stall) begin
          tgt = exc_req ? ExcVec : (eret ? epc : npc_in);
          if (tgt % 4 != 0) begin
            tgt     = ExcVec;
            m_fault = 1'b1;
          end
          m_pc         = tgt;
          m_count      = m_count + 32'd1;
          m_phase      = 1;
          m_req_cycles = 0;
          m_lat        = pick_lat(rnd);
        end
      end
    endcase

    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    rst_n      = 1'b0;
    npc_in     = '0;
    stall      = 1'b0;
    exc_req    = 1'b0;
    eret       = 1'b0;
    epc        = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    pulse_reset(1'b0);

    // Zero-wait sequential fetch from the reset PC.
    step(1'b0);
    check_eq("first_req", {31'd0, imem_req}, 32'd1);
    check_eq("first_addr", imem_addr, 32'h0000_3000);
    repeat (6) step(1'b0);
    check_eq("seq_count", fetch_count, 32'd3);

    repeat (3000) step(1'b1);

    // Reset while a fetch is outstanding; an ack during reset must be ignored.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_phase == 1 && m_req_cycles >= 1) found = 1'b1;
      else step(1'b1);
    end
    check_eq("reach_req", {31'd0, found}, 32'd1);
    pulse_reset(1'b1);
    step(1'b1);
    check_eq("restart_req", {31'd0, imem_req}, 32'd1);
    check_eq("restart_addr", imem_addr, 32'h0000_3000);
    repeat (400) step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the architectural PC register and sequences instruction fetch for the single-issue MIPS core. It issues one instruction-memory request per instruction over a req/ack handshake and holds the fetched word until the decode stage accepts it. It then loads the next PC from the next-PC computation, or from the exception vector or EPC. Sits between the next-PC adder/selector and the instruction memory port; drives the PC that the next-PC logic consumes.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded by reset.
EXC_VEC, 32'h0000_4180, exception entry address.
TIMEOUT, 16, max cycles waiting for imem_ack before bus error (range 2..255).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
npc_in  in  32  next PC from next-PC logic (sequential / branch / jump already resolved).
stall  in  1  decode not ready; hold current instruction.
exc_req  in  1  take exception at next PC update.
eret  in  1  return from exception at next PC update.
epc  in  32  return address for eret.
imem_req  out  1  fetch request, level.
imem_addr  out  32  fetch address (equals pc_out while imem_req=1).
imem_ack  in  1  fetch data valid this cycle.
imem_rdata  in  32  fetched instruction word.
pc_out  out  32  current PC.
instr_out  out  32  latched instruction.
instr_valid  out  1  instr_out valid for decode.
fault  out  1  one-cycle pulse: misaligned next PC or fetch timeout.
fetch_count  out  32  instructions accepted by decode, wraps at 2^32.

Behaviour:
- Reset (async, rst_n=0): pc_out=RESET_PC, instr_out=0, instr_valid=0, imem_req=0, fault=0, fetch_count=0, state=BOOT, wait counter=0.
- States: BOOT, REQ, VALID.
- BOOT: single cycle after reset release; imem_req=0; next state REQ.
- REQ: imem_req=1, imem_addr=pc_out; wait counter increments each cycle.
  - imem_ack=1: instr_out<=imem_rdata; instr_valid<=1 next cycle; counter cleared; go VALID. Ack seen in the same cycle as imem_req rise counts (zero-wait memory gives 2-cycle fetch: REQ, VALID).
  - Counter reaches TIMEOUT-1 with no ack: fault pulse, pc_out<=EXC_VEC, counter cleared, stay REQ (new request to vector).
  - imem_ack outside REQ is ignored.
- VALID: instr_valid=1, imem_req=0.
  - stall=1: hold pc_out, instr_out; no other change. exc_req/eret sampled only when stall=0.
  - stall=0 (accept): fetch_count+1; instr_valid<=0; go REQ; pc_out loads, in priority order:
    - exc_req: EXC_VEC.
    - eret: epc.
    - else: npc_in.
  - If the selected value has [1:0]!=0: load EXC_VEC instead and pulse fault.
- exc_req/eret in BOOT or REQ are ignored (decode only raises them against a valid instruction).
- Exactly one request per instruction; no speculative prefetch. Address is stable for the whole REQ dwell.
- Async reset mid-REQ drops imem_req immediately; the pending ack is not observed.
- fetch_count wraps 32'hFFFF_FFFF -> 0 silently.

Test Plan:
- Reset release, zero-wait memory returning 32'h2408_0005, npc_in=pc+4 -> imem_addr 0x3000, then 0x3004; instr_valid high one cycle each; fetch_count 1, 2.
- Memory acks after 3 wait cycles, stall=1 for 4 cycles in VALID -> imem_addr held at 0x3000 throughout REQ; instr_out held; pc_out unchanged until stall falls; fetch_count increments once.
- In VALID, exc_req=1, eret=1, npc_in=0x3100 -> pc_out=0x4180 (exception wins); then eret=1, epc=0x3008 -> next fetch at 0x3008.
- npc_in=0x3102 on accept -> fault pulses one cycle; next imem_addr=0x4180.
- No ack for TIMEOUT=16 cycles -> fault pulse on the 16th cycle; imem_addr switches to 0x4180; imem_req stays high.
- rst_n low mid-REQ at pc 0x3010 -> imem_req=0 immediately; pc_out=0x3000, fetch_count=0; late ack ignored; fetch restarts at 0x3000 after BOOT.
